// File: rtl/glb_mcast_ring.sv
// Multicast ring buffer: one write stream fanned out in order to every masked read port.
// Optional per-port occupancy output RdOcc is enabled by defining GLB_MCAST_RING_OCC_EN.
module glb_mcast_ring #(
    parameter int unsigned SRAM_WIDTH = 256,
    parameter int unsigned MAXPAR     = 4,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned NUM_RDPORT = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    localparam int unsigned DW        = SRAM_WIDTH * MAXPAR,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CfgVld,
    output logic                       CfgRdy,
    input  logic [ADDR_WIDTH-1:0]      CfgNum,
    input  logic [NUM_RDPORT-1:0]      CfgRdMask,
    output logic                       Done,
    input  logic [DW-1:0]              WrDat,
    input  logic                       WrDatVld,
    output logic                       WrDatRdy,
    output logic [DW*NUM_RDPORT-1:0]   RdDat,
    output logic [NUM_RDPORT-1:0]      RdDatVld,
    input  logic [NUM_RDPORT-1:0]      RdDatRdy
`ifdef GLB_MCAST_RING_OCC_EN
    ,
    output logic [NUM_RDPORT*(PW+1)-1:0] RdOcc
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   num_q;
    logic [NUM_RDPORT-1:0]   mask_q;
    logic [PW:0]             wptr_q;
    logic [PW:0]             rptr_q     [NUM_RDPORT];
    logic [ADDR_WIDTH-1:0]   written_q;
    logic [ADDR_WIDTH-1:0]   consumed_q [NUM_RDPORT];
    logic [NUM_RDPORT-1:0]   rd_vld_q;
    logic [DW-1:0]           rd_dat_q   [NUM_RDPORT];
    logic [DW-1:0]           mem        [DEPTH];

    logic                    cfg_fire;
    logic                    wr_fire;
    logic                    full;
    logic                    all_consumed;
    logic [PW:0]             occ        [NUM_RDPORT];
    logic [NUM_RDPORT-1:0]   issue;
    logic [NUM_RDPORT-1:0]   consume;

    // Ring status, evaluated on pre-edge pointers so a freeing read never enables a same-cycle write
    always_comb begin
        full         = 1'b0;
        all_consumed = 1'b1;
        issue        = '0;
        consume      = '0;
        for (int k = 0; k < NUM_RDPORT; k++) begin
            occ[k]     = wptr_q - rptr_q[k];
            consume[k] = rd_vld_q[k] & RdDatRdy[k];
            issue[k]   = (state_q == RUN) & mask_q[k] & (rptr_q[k] != wptr_q)
                         & (~rd_vld_q[k] | RdDatRdy[k]);
            if (mask_q[k] && occ[k] == (PW+1)'(DEPTH))
                full = 1'b1;
            if (mask_q[k] && consumed_q[k] != num_q)
                all_consumed = 1'b0;
        end
    end

    assign WrDatRdy = (state_q == RUN) & ~full & (written_q < num_q);
    assign wr_fire  = WrDatVld & WrDatRdy;
    assign cfg_fire = CfgVld & (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (CfgVld)
                      state_d = (CfgNum == '0 || CfgRdMask == '0) ? DONE : RUN;
            RUN:  if (written_q == num_q && all_consumed)
                      state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CfgRdy = 1'b0;
        Done   = 1'b0;
        case (state_q)
            IDLE:    CfgRdy = 1'b1;
            DONE:    Done   = 1'b1;
            default: ;
        endcase
    end

    // Pointers, counters and per-port output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            mask_q    <= '0;
            wptr_q    <= '0;
            written_q <= '0;
            rd_vld_q  <= '0;
            for (int k = 0; k < NUM_RDPORT; k++) begin
                rptr_q[k]     <= '0;
                consumed_q[k] <= '0;
                rd_dat_q[k]   <= '0;
            end
        end else if (cfg_fire) begin
            num_q     <= CfgNum;
            mask_q    <= CfgRdMask;
            wptr_q    <= '0;
            written_q <= '0;
            rd_vld_q  <= '0;
            for (int k = 0; k < NUM_RDPORT; k++) begin
                rptr_q[k]     <= '0;
                consumed_q[k] <= '0;
            end
        end else begin
            if (wr_fire) begin
                wptr_q    <= wptr_q + 1'b1;
                written_q <= written_q + 1'b1;
            end
            for (int k = 0; k < NUM_RDPORT; k++) begin
                if (consume[k])
                    consumed_q[k] <= consumed_q[k] + 1'b1;
                if (issue[k]) begin
                    rptr_q[k]   <= rptr_q[k] + 1'b1;
                    rd_dat_q[k] <= mem[rptr_q[k][PW-1:0]];
                    rd_vld_q[k] <= 1'b1;
                end else if (consume[k]) begin
                    rd_vld_q[k] <= 1'b0;
                end
            end
        end
    end

    // Ring storage carries no reset
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wptr_q[PW-1:0]] <= WrDat;
    end

    always_comb begin
        for (int k = 0; k < NUM_RDPORT; k++)
            RdDat[DW*k +: DW] = rd_dat_q[k];
    end

    assign RdDatVld = rd_vld_q;

`ifdef GLB_MCAST_RING_OCC_EN
    always_comb begin
        RdOcc = '0;
        for (int k = 0; k < NUM_RDPORT; k++)
            if (mask_q[k])
                RdOcc[(PW+1)*k +: (PW+1)] = occ[k];
    end
`endif

endmodule
